// File: rtl/regress_ctrl.sv
// Run controller for reference-vs-autogen datapath regressions: sequences a
// stimulus run, compares every lane LATENCY cycles after each vector, and reports errors.
module regress_ctrl #(
    parameter int DATAWIDTH   = 32,
    parameter int NUM_OUTS    = 2,
    parameter int LATENCY     = 2,
    parameter int NUM_VECTORS = 1000,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          Start,
    input  logic [NUM_OUTS*DATAWIDTH-1:0] Meas,
    input  logic [NUM_OUTS*DATAWIDTH-1:0] Ref,
    output logic                          StimEn,
    output logic                          Busy,
    output logic                          Done,
    output logic                          Pass,
    output logic [ERR_CNT_W-1:0]          ErrCnt,
    output logic [31:0]                   FirstErrIdx,
    output logic [NUM_OUTS-1:0]           FirstErrMask,
    output logic [NUM_OUTS-1:0]           ErrPulse
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [31:0] LAST_VEC   = 32'(NUM_VECTORS - 1);
    localparam logic [31:0] LAST_DRAIN = 32'(LATENCY - 1);

    state_e                 state_q, state_d;
    logic [31:0]            cnt_q, cnt_d;
    logic                   run_clear;
    logic                   stim_en;

    logic [LATENCY-1:0]     vld_q, vld_d;
    logic                   cmp_valid;
    logic [NUM_OUTS-1:0]    lane_mis;
    logic [31:0]            cmp_idx_q, cmp_idx_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [31:0]            first_idx_q, first_idx_d;
    logic [NUM_OUTS-1:0]    first_mask_q, first_mask_d;
    logic [NUM_OUTS-1:0]    err_pulse_q, err_pulse_d;

    // cnt_q is the vector index in RUN and the elapsed-cycle count in DRAIN.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        cnt_d     = cnt_q;
        run_clear = 1'b0;
        stim_en   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    run_clear = 1'b1;
                end
            end
            S_RUN: begin
                stim_en = 1'b1;
                if (cnt_q == LAST_VEC) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == LAST_DRAIN) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        vld_d[0] = stim_en;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        for (int n = 0; n < NUM_OUTS; n++) begin
            lane_mis[n] = (Meas[n*DATAWIDTH +: DATAWIDTH] != Ref[n*DATAWIDTH +: DATAWIDTH]);
        end
    end

    assign cmp_valid = vld_q[LATENCY-1];

    // The pipe is empty whenever run_clear fires, so clear and compare never collide.
    always_comb begin
        cmp_idx_d    = cmp_idx_q;
        err_cnt_d    = err_cnt_q;
        first_idx_d  = first_idx_q;
        first_mask_d = first_mask_q;
        err_pulse_d  = cmp_valid ? lane_mis : '0;
        if (run_clear) begin
            cmp_idx_d    = '0;
            err_cnt_d    = '0;
            first_idx_d  = '0;
            first_mask_d = '0;
        end else if (cmp_valid) begin
            cmp_idx_d = cmp_idx_q + 32'd1;
            if (|lane_mis) begin
                if (err_cnt_q == '0) begin
                    first_idx_d  = cmp_idx_q;
                    first_mask_d = lane_mis;
                end
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                end
            end
        end
    end

    // NOTE: reset is synchronous here, so Rst is simply the highest-priority branch on the clock edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            vld_q        <= '0;
            cmp_idx_q    <= '0;
            err_cnt_q    <= '0;
            first_idx_q  <= '0;
            first_mask_q <= '0;
            err_pulse_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vld_q        <= vld_d;
            cmp_idx_q    <= cmp_idx_d;
            err_cnt_q    <= err_cnt_d;
            first_idx_q  <= first_idx_d;
            first_mask_q <= first_mask_d;
            err_pulse_q  <= err_pulse_d;
        end
    end

    assign StimEn       = stim_en;
    assign Busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign Done         = (state_q == S_DONE);
    assign Pass         = Done && (err_cnt_q == '0);
    assign ErrCnt       = err_cnt_q;
    assign FirstErrIdx  = first_idx_q;
    assign FirstErrMask = first_mask_q;
    assign ErrPulse     = err_pulse_q;

endmodule

// File: tb/tb_regress_ctrl.sv
// Randomised scoreboard bench for regress_ctrl: a run-level model queues expected
// run summaries and error pulses; a negedge monitor pops and compares them.
module tb_regress_ctrl;

    localparam int N  = 8;
    localparam int L  = 2;
    localparam int DW = 32;
    localparam int NO = 2;
    localparam int BW = NO * DW;

    typedef struct {
        int              k;
        int              done_cyc;
        int              cnt;
        int              first_idx;
        logic [NO-1:0]   first_mask;
    } run_t;

    typedef struct {
        int              cyc;
        logic [NO-1:0]   mask;
    } pulse_t;

    logic           clk = 1'b0;
    logic           Rst = 1'b1;
    logic           Start = 1'b0;
    logic [BW-1:0]  Meas = '0;
    logic [BW-1:0]  Ref = '0;

    logic           StimEn, Busy, Done, Pass;
    logic [15:0]    ErrCnt;
    logic [31:0]    FirstErrIdx;
    logic [NO-1:0]  FirstErrMask, ErrPulse;

    logic           stim2, busy2, done2, pass2;
    logic [1:0]     ecnt2;
    logic [31:0]    fidx2;
    logic [NO-1:0]  fmask2, epulse2;

    regress_ctrl #(.DATAWIDTH(DW), .NUM_OUTS(NO), .LATENCY(L), .NUM_VECTORS(N), .ERR_CNT_W(16)) dut (
        .Clk(clk), .Rst(Rst), .Start(Start), .Meas(Meas), .Ref(Ref),
        .StimEn(StimEn), .Busy(Busy), .Done(Done), .Pass(Pass), .ErrCnt(ErrCnt),
        .FirstErrIdx(FirstErrIdx), .FirstErrMask(FirstErrMask), .ErrPulse(ErrPulse)
    );

    regress_ctrl #(.DATAWIDTH(DW), .NUM_OUTS(NO), .LATENCY(L), .NUM_VECTORS(N), .ERR_CNT_W(2)) dut_sat (
        .Clk(clk), .Rst(Rst), .Start(Start), .Meas(Meas), .Ref(Ref),
        .StimEn(stim2), .Busy(busy2), .Done(done2), .Pass(pass2), .ErrCnt(ecnt2),
        .FirstErrIdx(fidx2), .FirstErrMask(fmask2), .ErrPulse(epulse2)
    );

    always #5 clk = ~clk;

    int      n_cmp = 0;
    int      n_bad = 0;
    int      cyc = 0;
    int      busy_until = -1;
    int      mode = 0;
    bit      run_active = 1'b0;
    int      run_k = 0;
    bit      mon_en = 1'b0;
    logic [BW-1:0] plan_x [N];
    run_t    run_q[$];
    pulse_t  pulse_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s @cycle %0d", name, cyc);
    endtask

    function automatic logic [DW-1:0] nz_word();
        logic [DW-1:0] w;
        w = $urandom;
        if (w == '0) w = 1;
        return w;
    endfunction

    function automatic logic [BW-1:0] rand_bus();
        logic [BW-1:0] b;
        for (int n = 0; n < NO; n++) b[n*DW +: DW] = $urandom;
        return b;
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Plan a whole run at the cycle its Start is accepted.
    task automatic accept();
        int            cnt;
        int            first;
        int            lanes;
        logic [NO-1:0] fmask;
        logic [NO-1:0] m;
        logic [BW-1:0] x;
        cnt = 0; first = 0; fmask = '0;
        for (int i = 0; i < N; i++) begin
            x = '0;
            lanes = 0;
            case (mode)
                1: if (i == 3 || i == 5) x[DW] = 1'b1;
                2: lanes = $urandom_range(1, (1 << NO) - 1);
                3: if ($urandom_range(0, 3) == 0) lanes = $urandom_range(1, (1 << NO) - 1);
                default: ;
            endcase
            for (int n = 0; n < NO; n++) if (lanes[n]) x[n*DW +: DW] = nz_word();
            plan_x[i] = x;
            for (int n = 0; n < NO; n++) m[n] = (x[n*DW +: DW] != '0);
            if (m != '0) begin
                if (cnt == 0) begin
                    first = i;
                    fmask = m;
                end
                cnt++;
                pulse_q.push_back('{cyc + 2 + i + L, m});
            end
        end
        run_q.push_back('{cyc, cyc + N + L + 1, cnt, first, fmask});
        run_k      = cyc;
        run_active = 1'b1;
        busy_until = cyc + N + L;
    endtask

    // Drive one cycle of inputs, update the model, advance to #1 after the next edge.
    task automatic step(input logic start, input logic rst);
        logic [BW-1:0] r;
        logic [BW-1:0] m;
        int            i;
        r = rand_bus();
        m = rand_bus();
        i = cyc - (run_k + 1 + L);
        if (run_active && i >= 0 && i < N) m = r ^ plan_x[i];
        Start = start;
        Rst   = rst;
        Ref   = r;
        Meas  = m;
        if (rst) begin
            run_active = 1'b0;
            busy_until = cyc;
            while (pulse_q.size() > 0 && pulse_q[pulse_q.size()-1].cyc > cyc) void'(pulse_q.pop_back());
            while (run_q.size() > 0 && run_q[run_q.size()-1].done_cyc > cyc) void'(run_q.pop_back());
        end else if (start && cyc > busy_until) begin
            accept();
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stimen"}, StimEn, 0);
        check({tag, "_busy"}, Busy, 0);
        check({tag, "_done"}, Done, 0);
        check({tag, "_pass"}, Pass, 0);
        check({tag, "_errcnt"}, ErrCnt, 0);
        check({tag, "_firstidx"}, FirstErrIdx, 0);
        check({tag, "_firstmask"}, FirstErrMask, 0);
        check({tag, "_errpulse"}, ErrPulse, 0);
        check({tag, "_sat_errcnt"}, ecnt2, 0);
        check({tag, "_sat_busy"}, busy2, 0);
    endtask

    // Monitor: pops expectations when the DUT presents pulses or completes a run.
    bit prev_stim = 1'b0;
    bit prev_done = 1'b0;
    int stim_cnt = 0;
    int busy_cnt = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            pulse_t p;
            run_t   r;
            while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
                p = pulse_q.pop_front();
                $display("FAIL errpulse_missing @cycle %0d: expected mask %0h at cycle %0d", cyc, p.mask, p.cyc);
                n_cmp++;
                n_bad++;
            end
            if (ErrPulse != '0) begin
                if (pulse_q.size() == 0) begin
                    fail_now("errpulse_unexpected");
                end else begin
                    p = pulse_q.pop_front();
                    check("errpulse_cycle", cyc, p.cyc);
                    check("errpulse_mask", ErrPulse, p.mask);
                end
            end
            if (!Done) check("pass_without_done", Pass, 0);
            if (StimEn && !prev_stim) begin
                if (run_q.size() == 0) fail_now("stimen_unexpected");
                else check("stimen_first_cycle", cyc, run_q[0].k + 1);
            end
            stim_cnt += int'(StimEn);
            busy_cnt += int'(Busy);
            if (Done && !prev_done) begin
                if (run_q.size() == 0) begin
                    fail_now("done_unexpected");
                end else begin
                    r = run_q.pop_front();
                    check("done_cycle", cyc, r.done_cyc);
                    check("errcnt", ErrCnt, sat(r.cnt, 16));
                    check("sat_errcnt", ecnt2, sat(r.cnt, 2));
                    check("sat_done", done2, 1);
                    check("first_err_idx", FirstErrIdx, r.first_idx);
                    check("first_err_mask", FirstErrMask, r.first_mask);
                    check("pass", Pass, (r.cnt == 0));
                    check("stimen_cycles", stim_cnt, N);
                    check("busy_cycles", busy_cnt, N + L);
                end
                stim_cnt = 0;
                busy_cnt = 0;
            end
            prev_stim = StimEn;
            prev_done = Done;
            if (Rst) begin
                stim_cnt = 0;
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout @cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // Reset with random inputs.
        for (int j = 0; j < 10; j++) step(1'($urandom_range(0, 1)), 1'b1);
        @(negedge clk); #1;
        check_all_zero("reset");
        mon_en = 1'b1;

        // Clean run.
        idle(2);
        mode = 0;
        step(1'b1, 1'b0);
        idle(N + L + 4);

        // Lane-1 bit flips on vectors 3 and 5.
        mode = 1;
        step(1'b1, 1'b0);
        idle(N + L + 4);

        // Every vector mismatches: 2-bit counter saturates.
        mode = 2;
        step(1'b1, 1'b0);
        idle(N + L + 4);

        // Reset in the fourth RUN cycle, then a clean full run.
        mode = 2;
        k = cyc;
        step(1'b1, 1'b0);
        idle(3);
        step(1'b0, 1'b1);
        @(negedge clk); #1;
        check("midrun_reset_cycle", cyc, k + 5);
        check_all_zero("midrun_reset");
        mode = 0;
        step(1'b1, 1'b0);
        idle(N + L + 4);

        // Start held high across several back-to-back runs.
        mode = 3;
        for (int j = 0; j < 3 * (N + L + 1) + 1; j++) step(1'b1, 1'b0);
        idle(N + L + 4);

        // Random Start traffic, including Starts ignored while busy.
        for (int j = 0; j < 300; j++) begin
            mode = ($urandom_range(0, 1) == 0) ? 3 : 2;
            step(1'($urandom_range(0, 5) == 0), 1'b0);
        end

        // Drain with a bounded wait.
        for (int j = 0; j < 200 && run_q.size() > 0; j++) step(1'b0, 1'b0);
        idle(3);
        if (run_q.size() > 0) fail_now("drain_timeout");
        check("pulses_outstanding", pulse_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
